// File: rtl/filter2d_wb_pkg.sv
// rtl/filter2d_wb_pkg.sv - shared geometry defaults, state enum and FIFO entry types for filter2d_wb.
package filter2d_pkg;

    localparam int DEF_IMG_W      = 256;
    localparam int DEF_IMG_H      = 256;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_AW         = 14;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wb_state_t;

    // Entry layout for the default geometry; the top re-declares it with its own AW.
    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        word_t             data;
    } wb_entry_t;

endpackage

// File: rtl/filter2d_wb_if.sv
// rtl/filter2d_wb_if.sv - pixel input stream and ready-gated memory write port of filter2d_wb.
interface filter2d_wb_if #(
    parameter int AW = 14
) ();
    logic          i_strb;
    logic [7:0]    i_data;
    logic          mem_wr;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_ready;

    modport master (
        output i_strb, i_data, wr_ready,
        input  mem_wr, wr_addr, wr_data
    );

    modport slave (
        input  i_strb, i_data, wr_ready,
        output mem_wr, wr_addr, wr_data
    );
endinterface

// File: rtl/filter2d_wb_fifo.sv
// rtl/filter2d_wb_fifo.sv - synchronous word FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module filter2d_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 46
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // On full+pop the write lands in the slot being read out; the read sees the old word.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/filter2d_wb.sv
// rtl/filter2d_wb.sv - filter output write-back: packs 4 pixels per word into a FIFO feeding the frame memory.
// Optional macro FILTER2D_WB_CHECKSUM_EN adds a 16-bit running pixel sum output csum.
module filter2d_wb
    import filter2d_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AW         = DEF_AW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    filter2d_wb_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          ovf
`ifdef FILTER2D_WB_CHECKSUM_EN
    ,
    output logic [15:0]   csum
`endif
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        word_t         data;
    } entry_t;

    wb_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0] pack_q, pack_d;
    logic        ovf_q, ovf_d;
    logic        accept, push, pop, full, empty;
    logic [1:0]  lane;
    entry_t      push_e, head_e;

    assign lane   = cnt_q[1:0];
    assign accept = (state_q == RUN) && bus.i_strb && !start;
    assign push   = accept && (lane == 2'd3);
    assign pop    = !empty && bus.wr_ready;

    // Address comes from the pixel count, so dropped words never shift later ones.
    assign push_e.addr = AW'(cnt_q >> 2);
    assign push_e.data = {bus.i_data, pack_q};

    filter2d_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (start),
        .push  (push),
        .pop   (pop),
        .din   (push_e),
        .dout  (head_e),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            RUN:     if (accept && cnt_q == CW'(NPIX - 1)) state_d = DRAIN;
            DRAIN:   if (empty) begin
                         state_d = IDLE;
                         done    = 1'b1;
                     end
            default: state_d = state_q;
        endcase
        if (start) state_d = RUN;
    end

    always_comb begin
        cnt_d  = cnt_q;
        pack_d = pack_q;
        ovf_d  = ovf_q;
        if (start) begin
            cnt_d  = '0;
            pack_d = '0;
            ovf_d  = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
            case (lane)
                2'd0:    pack_d[7:0]   = bus.i_data;
                2'd1:    pack_d[15:8]  = bus.i_data;
                2'd2:    pack_d[23:16] = bus.i_data;
                default: pack_d        = pack_q;
            endcase
            if (push && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pack_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign ovf         = ovf_q;
    assign bus.mem_wr  = !empty;
    assign bus.wr_addr = empty ? '0 : head_e.addr;
    assign bus.wr_data = empty ? '0 : head_e.data;

`ifdef FILTER2D_WB_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start)       csum_d = '0;
        else if (accept) csum_d = csum_q + {8'd0, bus.i_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

endmodule
